mvm_seq_ctrl: RTL

Sequencer for the 8-MLP, 16×int8 early-out matrix-vector multiply datapath. It loads the VxV matrix from a valid/ready stream into the datapath BRAMs, then streams vectors into the datapath as B-wide blocks. It generates first/last/pause framing and limits the number of vectors in flight. It also registers datapath results onto a valid-qualified result stream.
It sits between the host/NoC-facing streams and the datapath instance.

---
 rtl/mvm_seq_pkg.sv | 20 ++
 rtl/mvm_seq_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mvm_seq_pkg.sv
// Shared types and derived-size helpers for the MVM sequencer.
package mvm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Number of Bw-wide beats needed to fill a VxV matrix.
  function automatic int calc_mat_words(input int v, input int bw);
    return (v * v) / bw;
  endfunction

  // Number of B-wide blocks per V-element vector.
  function automatic int calc_blks(input int v, input int b);
    return v / b;
  endfunction

endpackage

// File: rtl/mvm_seq_ctrl.sv
// Sequencer between host streams and the early-out MVM datapath: loads the
// matrix, frames vector blocks, bounds vectors in flight, registers results.
module mvm_seq_ctrl
  import mvm_seq_pkg::*;
#(
  parameter int V            = 256,
  parameter int N            = 8,
  parameter int B            = 16,
  parameter int Bw           = 8,
  parameter int S            = 48,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_load_start,
  input  logic [Bw*N-1:0] i_mat_data,
  input  logic            i_mat_valid,
  output logic            o_mat_ready,
  input  logic [B*N-1:0]  i_vec_data,
  input  logic            i_vec_valid,
  output logic            o_vec_ready,
  output logic            o_loaded,
  output logic            o_busy,
  output logic [Bw*N-1:0] o_mvm_matrix,
  output logic            o_mvm_matrix_wren,
  output logic            o_mvm_matrix_wrpause,
  output logic [B*N-1:0]  o_mvm_v,
  output logic            o_mvm_first,
  output logic            o_mvm_last,
  output logic            o_mvm_pause,
  input  logic [S-1:0]    i_mvm_sum,
  input  logic            i_mvm_first,
  input  logic            i_mvm_last,
  input  logic            i_mvm_pause,
  output logic [S-1:0]    o_res_data,
  output logic            o_res_valid,
  output logic            o_res_first,
  output logic            o_res_last
);

  localparam int MAT_WORDS = calc_mat_words(V, Bw);
  localparam int BLKS      = calc_blks(V, B);
  localparam int WCW       = (MAT_WORDS > 1) ? $clog2(MAT_WORDS) : 1;
  localparam int BCW       = (BLKS > 1) ? $clog2(BLKS) : 1;
  localparam int IFW       = $clog2(MAX_INFLIGHT + 1);

  state_t           r_state, w_next;
  logic [WCW-1:0]   r_word_cnt;
  logic [BCW-1:0]   r_blk_cnt;
  logic [IFW-1:0]   r_inflight;

  logic w_mat_ready, w_vec_ready;
  logic w_mat_acc, w_vec_acc;
  logic w_last_word, w_blk_first, w_blk_last;
  logic w_enter_load, w_inc, w_dec;

  assign w_last_word  = (r_word_cnt == WCW'(MAT_WORDS - 1));
  assign w_blk_first  = (r_blk_cnt == '0);
  assign w_blk_last   = (r_blk_cnt == BCW'(BLKS - 1));

  // Mid-vector blocks are always admitted so an open vector can finish;
  // only the start of a new vector is gated by the in-flight limit.
  assign w_mat_ready  = (r_state == LOAD);
  assign w_vec_ready  = (r_state == RUN) &&
                        (!w_blk_first || (r_inflight < IFW'(MAX_INFLIGHT)));
  assign w_mat_acc    = w_mat_ready && i_mat_valid;
  assign w_vec_acc    = w_vec_ready && i_vec_valid;
  assign w_enter_load = (r_state != LOAD) && (w_next == LOAD);
  assign w_inc        = w_vec_acc && w_blk_first;
  assign w_dec        = i_mvm_last && !i_mvm_pause;

  assign o_mat_ready  = w_mat_ready;
  assign o_vec_ready  = w_vec_ready;
  assign o_busy       = (r_state == LOAD) || (r_inflight != '0) || !w_blk_first;

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next state; a reload from RUN waits for a fully quiet datapath.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (i_load_start) w_next = LOAD;
      LOAD: if (w_mat_acc && w_last_word) w_next = RUN;
      RUN:  if (i_load_start && w_blk_first && (r_inflight == '0) && !w_vec_acc)
              w_next = LOAD;
      default: w_next = IDLE;
    endcase
  end

  // Matrix word counter and resident flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_word_cnt <= '0;
      o_loaded   <= 1'b0;
    end else begin
      if (w_enter_load)   r_word_cnt <= '0;
      else if (w_mat_acc) r_word_cnt <= r_word_cnt + 1'b1;
      if (w_mat_acc && w_last_word) o_loaded <= 1'b1;
      else if (w_enter_load)        o_loaded <= 1'b0;
    end
  end

  // Matrix write port: every LOAD cycle is a write slot, paused when no beat.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_mvm_matrix         <= '0;
      o_mvm_matrix_wren    <= 1'b0;
      o_mvm_matrix_wrpause <= 1'b0;
    end else begin
      o_mvm_matrix_wren    <= w_mat_ready;
      o_mvm_matrix_wrpause <= w_mat_ready && !i_mat_valid;
      if (w_mat_ready) o_mvm_matrix <= i_mat_data;
    end
  end

  // Vector framing toward the datapath; data holds across pauses.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_mvm_v     <= '0;
      o_mvm_first <= 1'b0;
      o_mvm_last  <= 1'b0;
      o_mvm_pause <= 1'b1;
      r_blk_cnt   <= '0;
    end else if (w_vec_acc) begin
      o_mvm_v     <= i_vec_data;
      o_mvm_first <= w_blk_first;
      o_mvm_last  <= w_blk_last;
      o_mvm_pause <= 1'b0;
      r_blk_cnt   <= w_blk_last ? '0 : r_blk_cnt + 1'b1;
    end else begin
      o_mvm_first <= 1'b0;
      o_mvm_last  <= 1'b0;
      o_mvm_pause <= 1'b1;
    end
  end

  // Vectors started but not yet retired by the datapath; saturates at zero.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_inflight <= '0;
    end else begin
      case ({w_inc, w_dec})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   if (r_inflight != '0) r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  a_no_underflow: assert property (@(posedge i_clk) disable iff (i_reset)
    !(w_dec && !w_inc && (r_inflight == '0)));

  // Result stage: one register behind the datapath, framing gated by pause.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_res_data  <= '0;
      o_res_valid <= 1'b0;
      o_res_first <= 1'b0;
      o_res_last  <= 1'b0;
    end else begin
      o_res_data  <= i_mvm_sum;
      o_res_valid <= !i_mvm_pause;
      o_res_first <= i_mvm_first && !i_mvm_pause;
      o_res_last  <= i_mvm_last && !i_mvm_pause;
    end
  end

endmodule
